// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned LEN_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles accepted bytes into little-endian 32-bit words; word_valid marks the 4th byte.
module byte_word_packer
  import boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clear) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (byte_valid) begin
      cnt_d   = cnt_q + 2'd1;
      shreg_d = {byte_in, shreg_q[31:8]};
    end
  end

  // Bytes enter at the top and shift down, so byte 0 ends up in bits [7:0].
  assign word_valid = byte_valid && !clear && (cnt_q == 2'(WORD_BYTES - 1));
  assign word       = {byte_in, shreg_q[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the CPU in reset until done.
// Optional trailing XOR checksum byte is enabled by defining BOOT_CHECKSUM_EN.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W:0]   wl_q, wl_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]        xor_q, xor_d;
`endif

  logic             accept;
  logic             start_ok;
  logic             pk_valid;
  logic             pk_word_valid;
  logic [31:0]      pk_word;
  logic [LEN_W-1:0] hdr_len;
  logic             all_words;

  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state_q == IDLE || state_q == DONE || state_q == ERROR);
  assign pk_valid  = accept && (state_q == DATA);
  assign hdr_len   = {in_data, len_lo_q};
  assign all_words = (LEN_W'(wl_q) == len_q);

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_valid (pk_valid),
    .byte_in    (in_data),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  // DATA stops accepting once the last word is captured so no trailing byte is consumed.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      LEN_LO, LEN_HI, CHECK: in_ready = 1'b1;
      DATA:                  in_ready = !all_words;
      default:               in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    wl_d     = wl_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef BOOT_CHECKSUM_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start_ok) begin
          state_d = LEN_LO;
          wl_d    = '0;
`ifdef BOOT_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_lo_d = in_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          len_d = hdr_len;
          if (hdr_len > LEN_W'(MEM_WORDS)) begin
            state_d = ERROR;
          end else if (hdr_len == '0) begin
`ifdef BOOT_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
`ifdef BOOT_CHECKSUM_EN
        if (pk_valid) xor_d = xor_q ^ in_data;
`endif
        if (pk_word_valid) begin
          we_d    = 1'b1;
          addr_d  = wl_q[ADDR_W-1:0];
          wdata_d = pk_word;
          wl_d    = wl_q + 1'b1;
        end
        // wl_q reaches N on the edge that raises imem_we, so this leaves DATA one cycle later.
        if (all_words) begin
`ifdef BOOT_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
      CHECK: begin
`ifdef BOOT_CHECKSUM_EN
        if (accept) state_d = (in_data == xor_q) ? DONE : ERROR;
`else
        state_d = ERROR;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      len_q    <= '0;
      wl_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      wl_q     <= wl_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef BOOT_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign words_loaded = wl_q;
  assign done         = (state_q == DONE);
  assign error        = (state_q == ERROR);
  assign cpu_rst      = (state_q != DONE);

endmodule
